// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences ADD/AND/XOR/SRA (1 pass) and SUB/OR (3 passes) over an external ALU; in_* request, out_* result, alu_* ALU port
module alu_op_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_err,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);
  typedef enum logic [2:0] {IDLE, PASS1, PASS2, PASS3, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op_r;
  logic [XLEN-1:0] a_r, b_r, t, u;
  logic sub, multi, illegal;
  assign sub = op_r == 3'd4;
  assign multi = sub || op_r == 3'd5;
  assign illegal = op_r[2] & op_r[1];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_n = state;
    alu_a = '0;
    alu_b = '0;
    alu_ctrl = '0;
    case (state)
      IDLE: state_n = in_valid ? PASS1 : IDLE;
      PASS1: begin
        state_n = multi ? PASS2 : DONE;
        if (!illegal) begin
          alu_a = sub ? b_r : a_r;
          alu_b = sub ? {XLEN{1'b1}} : b_r;
          alu_ctrl = multi ? 4'd2 : {2'b00, op_r[1:0]};
        end
      end
      PASS2: begin
        state_n = PASS3;
        alu_a = a_r;
        alu_b = sub ? t : b_r;
        alu_ctrl = sub ? 4'd0 : 4'd1;
      end
      PASS3: begin
        state_n = DONE;
        alu_a = t;
        alu_b = sub ? XLEN'(1) : u;
      end
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      t <= '0;
      u <= '0;
      out_result <= '0;
      out_zero <= 1'b0;
      out_err <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (in_valid) begin
          op_r <= op;
          a_r <= src_a;
          b_r <= src_b;
        end
        PASS1: if (illegal) begin
          out_result <= '0;
          out_zero <= 1'b1;
          out_err <= 1'b1;
        end else if (multi) t <= alu_result;
        else begin
          out_result <= alu_result;
          out_zero <= alu_zero;
        end
        PASS2: if (sub) t <= alu_result; else u <= alu_result;
        PASS3: begin
          out_result <= alu_result;
          out_zero <= alu_zero;
        end
        DONE: if (out_ready) begin
          out_result <= '0;
          out_zero <= 1'b0;
          out_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench with an ALU stub and a transaction-level reference model
module tb_alu_op_sequencer;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_zero, out_err, alu_zero;
  logic [2:0] op = 0;
  logic [31:0] src_a = 0, src_b = 0, out_result, alu_a, alu_b, alu_result;
  logic [3:0] alu_ctrl;
  int tests = 0, fails = 0;
  logic chk = 0;
  int m_st = 0, m_cnt = 0;
  logic [31:0] m_res = 0;
  logic m_zero = 0, m_err = 0;
  always #5 clk = ~clk;
  alu_op_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_err(out_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );
  always_comb begin
    alu_result = alu_ctrl == 4'd0 ? alu_a + alu_b :
                 alu_ctrl == 4'd1 ? alu_a & alu_b :
                 alu_ctrl == 4'd2 ? alu_a ^ alu_b :
                 alu_ctrl == 4'd3 ? 32'($signed(alu_a) >>> alu_b[4:0]) : 32'd0;
    alu_zero = alu_result == 32'd0;
  end
  function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] a, b);
    case (o)
      3'd0: return a + b;
      3'd1: return a & b;
      3'd2: return a ^ b;
      3'd3: return 32'($signed(a) >>> b[4:0]);
      3'd4: return a - b;
      3'd5: return a | b;
      default: return 32'd0;
    endcase
  endfunction
  always @(posedge clk) begin
    if (rst) m_st <= 0;
    else if (m_st == 0) begin
      if (in_valid) begin
        m_st <= 1;
        m_cnt <= (op == 3'd4 || op == 3'd5) ? 3 : 1;
        m_res <= model_res(op, src_a, src_b);
        m_zero <= model_res(op, src_a, src_b) == 32'd0;
        m_err <= op > 3'd5;
      end
    end else if (m_st == 1) begin
      if (m_cnt == 1) m_st <= 2;
      else m_cnt <= m_cnt - 1;
    end else if (out_ready) m_st <= 0;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk) begin
    check("m_in_ready", 32'(in_ready), 32'(m_st == 0));
    check("m_out_valid", 32'(out_valid), 32'(m_st == 2));
    check("m_out_err", 32'(out_err), 32'(m_st == 2 && m_err));
    check("m_out_result", out_result, m_st == 2 ? m_res : 32'd0);
    if (m_st == 2) check("m_out_zero", 32'(out_zero), 32'(m_zero));
    if (m_st != 1) check("m_alu_idle", {alu_a | alu_b, 28'd0, alu_ctrl} == 64'd0 ? 32'd1 : 32'd0, 32'd1);
  end
  task automatic run(input string nm, input logic [2:0] o, input logic [31:0] a, b, input int d,
                     input logic [31:0] er, input logic ez, ee, input int el, input logic [11:0] et);
    int n;
    logic [11:0] tr;
    @(negedge clk);
    op = o; src_a = a; src_b = b; in_valid = 1; out_ready = d == 0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({nm, "_accept_timeout"}, 32'd0, 32'd1);
      in_valid = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    n = 1; tr = 0;
    while (!out_valid && n < 20) begin
      if (n <= 3) tr[4*(n-1) +: 4] = alu_ctrl;
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, 32'(n - 1), 32'(el));
    if (!out_valid) return;
    check({nm, "_ctrl_trace"}, 32'(tr), 32'(et));
    check({nm, "_result"}, out_result, er);
    check({nm, "_zero"}, 32'(out_zero), 32'(ez));
    check({nm, "_err"}, 32'(out_err), 32'(ee));
    check({nm, "_model_pin"}, m_res, er);
    repeat (d) begin
      @(negedge clk);
      check({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({nm, "_hold_result"}, out_result, er);
      check({nm, "_hold_flags"}, {30'd0, out_zero, out_err}, {30'd0, ez, ee});
      check({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check({nm, "_post_in_ready"}, 32'(in_ready), 32'd1);
    check({nm, "_post_valid"}, 32'(out_valid), 32'd0);
    out_ready = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", out_result, 32'd0);
    check("reset_flags", {30'd0, out_zero, out_err}, 32'd0);
    check("reset_alu_ctrl", 32'(alu_ctrl), 32'd0);
    rst = 0;
    chk = 1;
    run("add_ovf", 3'd0, 32'h7FFFFFFF, 32'd1, 0, 32'h80000000, 0, 0, 1, 12'h000);
    run("sub_eq", 3'd4, 32'd5, 32'd5, 5, 32'd0, 1, 0, 3, 12'h002);
    run("sub_wrap", 3'd4, 32'd0, 32'd1, 0, 32'hFFFFFFFF, 0, 0, 3, 12'h002);
    run("or", 3'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'hFFF0FFF0, 0, 0, 3, 12'h012);
    run("sra", 3'd3, 32'h80000000, 32'h24, 0, 32'hF8000000, 0, 0, 1, 12'h003);
    run("ill7", 3'd7, 32'h12345678, 32'h1, 0, 32'd0, 1, 1, 1, 12'h000);
    run("and", 3'd1, 32'hFF00FF00, 32'h0F0F0F0F, 0, 32'h0F000F00, 0, 0, 1, 12'h001);
    run("xor_z", 3'd2, 32'h12345678, 32'h12345678, 0, 32'd0, 1, 0, 1, 12'h002);
    run("ill6", 3'd6, 32'h1, 32'h1, 2, 32'd0, 1, 1, 1, 12'h000);
    @(negedge clk);
    op = 3'd4; src_a = 32'd9; src_b = 32'd3; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_mid_idle", 32'(in_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_no_valid", 32'(out_valid), 32'd0);
    end
    run("add_after_rst", 3'd0, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 1, 0, 1, 12'h000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
